// File: rtl/proc_seq.sv
// Packet sequencer: one parser pass, then up to NUM_STAGES match-action stages on
// a shared matcher/executor, with a per-invocation watchdog and a unit memory mux.
module proc_seq #(
  parameter  int NUM_STAGES = 4,
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int TIMEOUT    = 1023,
  localparam int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [NUM_STAGES-1:0] hit_vec_o,
  input  logic                  cfg_we_i,
  input  logic [SW-1:0]         cfg_stage_i,
  input  logic [ADDR_W-1:0]     cfg_hit_addr_i,
  input  logic [ADDR_W-1:0]     cfg_miss_addr_i,
  input  logic                  cfg_en_i,
  output logic                  ps_start_o,
  input  logic                  ps_ready_i,
  output logic                  mt_start_o,
  output logic [SW-1:0]         mt_stage_o,
  input  logic                  mt_ready_i,
  input  logic [ADDR_W-1:0]     mt_val_addr_i,
  output logic                  ex_start_o,
  output logic [ADDR_W-1:0]     ex_start_addr_o,
  output logic [ADDR_W-1:0]     ex_args_addr_o,
  input  logic                  ex_ready_i,
  input  logic                  ps_mem_ce_i,
  input  logic                  ps_mem_we_i,
  input  logic [ADDR_W-1:0]     ps_mem_addr_i,
  input  logic [3:0]            ps_mem_width_i,
  input  logic [DATA_W-1:0]     ps_mem_data_i,
  input  logic                  mt_mem_ce_i,
  input  logic                  mt_mem_we_i,
  input  logic [ADDR_W-1:0]     mt_mem_addr_i,
  input  logic [3:0]            mt_mem_width_i,
  input  logic [DATA_W-1:0]     mt_mem_data_i,
  input  logic                  ex_mem_ce_i,
  input  logic                  ex_mem_we_i,
  input  logic [ADDR_W-1:0]     ex_mem_addr_i,
  input  logic [3:0]            ex_mem_width_i,
  input  logic [DATA_W-1:0]     ex_mem_data_i,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_width_o,
  output logic [DATA_W-1:0]     mem_data_o
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, PARSE, MATCH, EXEC, GAP, DONE} state_t;

  state_t                state_reg, state_next;
  logic [SW-1:0]         cur_reg, cur_next;
  logic                  ps_start_reg, ps_start_next;
  logic                  mt_start_reg, mt_start_next;
  logic                  ex_start_reg, ex_start_next;
  logic                  ready_reg, ready_next;
  logic                  err_reg, err_next;
  logic [NUM_STAGES-1:0] hit_vec_reg, hit_vec_next;
  logic [ADDR_W-1:0]     ex_addr_reg, ex_addr_next;
  logic [ADDR_W-1:0]     args_reg, args_next;
  logic [WD_W-1:0]       wd_reg, wd_next, wd_inc;
  logic                  wd_expire;
  logic                  abort;

  logic [ADDR_W-1:0]     tbl_hit  [NUM_STAGES];
  logic [ADDR_W-1:0]     tbl_miss [NUM_STAGES];
  logic [NUM_STAGES-1:0] tbl_en;
  logic                  cfg_ok;

  logic                  any_en, any_above;
  logic [SW-1:0]         first_en, next_en;
  logic                  mt_hit;

  // Table writes only land while no packet is in flight.
  assign cfg_ok = cfg_we_i && ((state_reg == IDLE) || (state_reg == DONE));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic [ADDR_W-1:0] hit_reg, miss_reg;
      logic              en_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hit_reg  <= '0;
          miss_reg <= '0;
          en_reg   <= 1'b0;
        end else if (cfg_ok && (cfg_stage_i == SW'(gi))) begin
          hit_reg  <= cfg_hit_addr_i;
          miss_reg <= cfg_miss_addr_i;
          en_reg   <= cfg_en_i;
        end
      end

      assign tbl_hit[gi]  = hit_reg;
      assign tbl_miss[gi] = miss_reg;
      assign tbl_en[gi]   = en_reg;
    end
  endgenerate

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    any_en    = 1'b0;
    any_above = 1'b0;
    first_en  = '0;
    next_en   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (tbl_en[i]) begin
        any_en   = 1'b1;
        first_en = SW'(i);
        if (i > int'(cur_reg)) begin
          any_above = 1'b1;
          next_en   = SW'(i);
        end
      end
    end
  end

  assign mt_hit    = (mt_val_addr_i != '0);
  assign wd_inc    = wd_reg + 1'b1;
  assign wd_expire = (TIMEOUT != 0) && (wd_inc == WD_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cur_reg      <= '0;
      ps_start_reg <= 1'b0;
      mt_start_reg <= 1'b0;
      ex_start_reg <= 1'b0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      hit_vec_reg  <= '0;
      ex_addr_reg  <= '0;
      args_reg     <= '0;
      wd_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      ps_start_reg <= ps_start_next;
      mt_start_reg <= mt_start_next;
      ex_start_reg <= ex_start_next;
      ready_reg    <= ready_next;
      err_reg      <= err_next;
      hit_vec_reg  <= hit_vec_next;
      ex_addr_reg  <= ex_addr_next;
      args_reg     <= args_next;
      wd_reg       <= wd_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    ps_start_next = ps_start_reg;
    mt_start_next = mt_start_reg;
    ex_start_next = ex_start_reg;
    ready_next    = ready_reg;
    err_next      = err_reg;
    hit_vec_next  = hit_vec_reg;
    ex_addr_next  = ex_addr_reg;
    args_next     = args_reg;
    wd_next       = wd_reg;
    abort         = 1'b0;

    case (state_reg)
      IDLE: begin
        // A simultaneous config write defers the start by one cycle.
        if (start_i && !cfg_we_i) begin
          ps_start_next = 1'b1;
          ready_next    = 1'b0;
          err_next      = 1'b0;
          hit_vec_next  = '0;
          wd_next       = '0;
          state_next    = PARSE;
        end
      end
      PARSE: begin
        wd_next = wd_inc;
        if (ps_ready_i && ps_start_reg) begin
          ps_start_next = 1'b0;
          if (!any_en) begin
            ready_next = 1'b1;
            state_next = DONE;
          end else begin
            cur_next      = first_en;
            mt_start_next = 1'b1;
            wd_next       = '0;
            state_next    = MATCH;
          end
        end else if (wd_expire) begin
          abort = 1'b1;
        end
      end
      MATCH: begin
        wd_next = wd_inc;
        if (mt_ready_i && mt_start_reg) begin
          mt_start_next         = 1'b0;
          args_next             = mt_val_addr_i;
          hit_vec_next[cur_reg] = mt_hit;
          ex_addr_next          = mt_hit ? tbl_hit[cur_reg] : tbl_miss[cur_reg];
          ex_start_next         = 1'b1;
          wd_next               = '0;
          state_next            = EXEC;
        end else if (wd_expire) begin
          abort = 1'b1;
        end
      end
      EXEC: begin
        wd_next = wd_inc;
        if (ex_ready_i && ex_start_reg) begin
          ex_start_next = 1'b0;
          if (any_above) begin
            state_next = GAP;
          end else begin
            ready_next = 1'b1;
            state_next = DONE;
          end
        end else if (wd_expire) begin
          abort = 1'b1;
        end
      end
      GAP: begin
        cur_next      = next_en;
        mt_start_next = 1'b1;
        wd_next       = '0;
        state_next    = MATCH;
      end
      DONE: begin
        if (!start_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      ps_start_next = 1'b0;
      mt_start_next = 1'b0;
      ex_start_next = 1'b0;
      err_next      = 1'b1;
      ready_next    = 1'b1;
      state_next    = DONE;
    end
  end

  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = '0;
    mem_data_o  = '0;
    case (state_reg)
      PARSE: begin
        mem_ce_o    = ps_mem_ce_i;
        mem_we_o    = ps_mem_we_i;
        mem_addr_o  = ps_mem_addr_i;
        mem_width_o = ps_mem_width_i;
        mem_data_o  = ps_mem_data_i;
      end
      MATCH: begin
        mem_ce_o    = mt_mem_ce_i;
        mem_we_o    = mt_mem_we_i;
        mem_addr_o  = mt_mem_addr_i;
        mem_width_o = mt_mem_width_i;
        mem_data_o  = mt_mem_data_i;
      end
      EXEC: begin
        mem_ce_o    = ex_mem_ce_i;
        mem_we_o    = ex_mem_we_i;
        mem_addr_o  = ex_mem_addr_i;
        mem_width_o = ex_mem_width_i;
        mem_data_o  = ex_mem_data_i;
      end
      default: ;
    endcase
  end

  assign ready_o         = ready_reg;
  assign busy_o          = (state_reg != IDLE) && (state_reg != DONE);
  assign err_o           = err_reg;
  assign hit_vec_o       = hit_vec_reg;
  assign ps_start_o      = ps_start_reg;
  assign mt_start_o      = mt_start_reg;
  assign mt_stage_o      = cur_reg;
  assign ex_start_o      = ex_start_reg;
  assign ex_start_addr_o = ex_addr_reg;
  assign ex_args_addr_o  = args_reg;

endmodule

// File: tb/tb_proc_seq.sv
// Directed bench for proc_seq: single/multi-stage packets, empty table, watchdog
// abort, config gating and asynchronous reset mid-packet.
module tb_proc_seq;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, ready_o, busy_o, err_o;
  logic [NS-1:0] hit_vec_o;
  logic          cfg_we_i, cfg_en_i;
  logic [SW-1:0] cfg_stage_i;
  logic [AW-1:0] cfg_hit_addr_i, cfg_miss_addr_i;
  logic          ps_start_o, ps_ready_i;
  logic          mt_start_o, mt_ready_i;
  logic [SW-1:0] mt_stage_o;
  logic [AW-1:0] mt_val_addr_i;
  logic          ex_start_o, ex_ready_i;
  logic [AW-1:0] ex_start_addr_o, ex_args_addr_o;
  logic          ps_mem_ce_i, ps_mem_we_i, mt_mem_ce_i, mt_mem_we_i, ex_mem_ce_i, ex_mem_we_i;
  logic [AW-1:0] ps_mem_addr_i, mt_mem_addr_i, ex_mem_addr_i;
  logic [3:0]    ps_mem_width_i, mt_mem_width_i, ex_mem_width_i;
  logic [DW-1:0] ps_mem_data_i, mt_mem_data_i, ex_mem_data_i;
  logic          mem_ce_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_width_o;
  logic [DW-1:0] mem_data_o;

  int total = 0;
  int bad   = 0;

  proc_seq #(.NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ready_o(ready_o), .busy_o(busy_o),
    .err_o(err_o), .hit_vec_o(hit_vec_o), .cfg_we_i(cfg_we_i), .cfg_stage_i(cfg_stage_i),
    .cfg_hit_addr_i(cfg_hit_addr_i), .cfg_miss_addr_i(cfg_miss_addr_i), .cfg_en_i(cfg_en_i),
    .ps_start_o(ps_start_o), .ps_ready_i(ps_ready_i), .mt_start_o(mt_start_o),
    .mt_stage_o(mt_stage_o), .mt_ready_i(mt_ready_i), .mt_val_addr_i(mt_val_addr_i),
    .ex_start_o(ex_start_o), .ex_start_addr_o(ex_start_addr_o), .ex_args_addr_o(ex_args_addr_o),
    .ex_ready_i(ex_ready_i),
    .ps_mem_ce_i(ps_mem_ce_i), .ps_mem_we_i(ps_mem_we_i), .ps_mem_addr_i(ps_mem_addr_i),
    .ps_mem_width_i(ps_mem_width_i), .ps_mem_data_i(ps_mem_data_i),
    .mt_mem_ce_i(mt_mem_ce_i), .mt_mem_we_i(mt_mem_we_i), .mt_mem_addr_i(mt_mem_addr_i),
    .mt_mem_width_i(mt_mem_width_i), .mt_mem_data_i(mt_mem_data_i),
    .ex_mem_ce_i(ex_mem_ce_i), .ex_mem_we_i(ex_mem_we_i), .ex_mem_addr_i(ex_mem_addr_i),
    .ex_mem_width_i(ex_mem_width_i), .ex_mem_data_i(ex_mem_data_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic start_of(input int which);
    case (which)
      0:       return ps_start_o;
      1:       return mt_start_o;
      default: return ex_start_o;
    endcase
  endfunction

  function automatic logic [31:0] unit_addr(input int which);
    case (which)
      0:       return 32'h1111;
      1:       return 32'h2222;
      default: return 32'h3333;
    endcase
  endfunction

  task automatic cfg(input int stage, input logic [31:0] hit, input logic [31:0] miss, input logic en);
    cfg_we_i        = 1'b1;
    cfg_stage_i     = SW'(stage);
    cfg_hit_addr_i  = hit;
    cfg_miss_addr_i = miss;
    cfg_en_i        = en;
    tick();
    cfg_we_i        = 1'b0;
  endtask

  // Waits (bounded) for the unit's start, checks the bus routing, answers for one edge.
  task automatic step_unit(input int which, input logic [31:0] val);
    int n = 0;
    while (start_of(which) !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check($sformatf("start_up%0d", which), 32'(start_of(which)), 32'd1);
    check($sformatf("mem_addr%0d", which), mem_addr_o, unit_addr(which));
    case (which)
      0: ps_ready_i = 1'b1;
      1: begin mt_ready_i = 1'b1; mt_val_addr_i = val; end
      default: ex_ready_i = 1'b1;
    endcase
    tick();
    ps_ready_i = 1'b0;
    mt_ready_i = 1'b0;
    ex_ready_i = 1'b0;
    check($sformatf("start_dn%0d", which), 32'(start_of(which)), 32'd0);
  endtask

  task automatic end_packet();
    start_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    start_i = 1'b0; cfg_we_i = 1'b0; cfg_en_i = 1'b0; cfg_stage_i = '0;
    cfg_hit_addr_i = '0; cfg_miss_addr_i = '0;
    ps_ready_i = 1'b0; mt_ready_i = 1'b0; ex_ready_i = 1'b0; mt_val_addr_i = '0;
    ps_mem_ce_i = 1'b1; ps_mem_we_i = 1'b0; ps_mem_addr_i = 32'h1111; ps_mem_width_i = 4'h1; ps_mem_data_i = 32'hA;
    mt_mem_ce_i = 1'b1; mt_mem_we_i = 1'b0; mt_mem_addr_i = 32'h2222; mt_mem_width_i = 4'h2; mt_mem_data_i = 32'hB;
    ex_mem_ce_i = 1'b1; ex_mem_we_i = 1'b1; ex_mem_addr_i = 32'h3333; ex_mem_width_i = 4'h4; ex_mem_data_i = 32'hC;
    tick(); tick();

    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_memce", 32'(mem_ce_o), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_hitvec", 32'(hit_vec_o), 32'd0);
    check("idle_stage", 32'(mt_stage_o), 32'd0);
    check("idle_starts", 32'({ps_start_o, mt_start_o, ex_start_o}), 32'd0);
    check("idle_memaddr", mem_addr_o, 32'd0);

    // Single stage, hit.
    cfg(0, 32'h100, 32'h200, 1'b1);
    start_i = 1'b1;
    tick();
    check("t1_busy", 32'(busy_o), 32'd1);
    step_unit(0, 0);
    check("t1_mt_start", 32'(mt_start_o), 32'd1);
    check("t1_stage", 32'(mt_stage_o), 32'd0);
    step_unit(1, 32'h40);
    check("t1_ex_start", 32'(ex_start_o), 32'd1);
    check("t1_ex_addr", ex_start_addr_o, 32'h100);
    check("t1_args", ex_args_addr_o, 32'h40);
    step_unit(2, 0);
    check("t1_ready", 32'(ready_o), 32'd1);
    check("t1_err", 32'(err_o), 32'd0);
    check("t1_hitvec", 32'(hit_vec_o), 32'h1);
    check("t1_busy_done", 32'(busy_o), 32'd0);
    end_packet();
    check("t1_ready_hold", 32'(ready_o), 32'd1);
    $display("pkt single_stage ready=%0b hit_vec=%b", ready_o, hit_vec_o);

    // Stages 0,1,3 enabled; matcher answers miss, hit, miss.
    cfg(1, 32'h110, 32'h210, 1'b1);
    cfg(2, 32'h120, 32'h220, 1'b0);
    cfg(3, 32'h130, 32'h230, 1'b1);
    start_i = 1'b1;
    tick();
    check("t2_ready_clr", 32'(ready_o), 32'd0);
    step_unit(0, 0);
    check("t2_stage_a", 32'(mt_stage_o), 32'd0);
    step_unit(1, 32'h0);
    check("t2_addr_a", ex_start_addr_o, 32'h200);
    step_unit(2, 0);
    check("t2_gap_a", 32'({ps_start_o, mt_start_o, ex_start_o}), 32'd0);
    check("t2_gap_busy", 32'(busy_o), 32'd1);
    check("t2_gap_memce", 32'(mem_ce_o), 32'd0);
    tick();
    check("t2_mt_b", 32'(mt_start_o), 32'd1);
    check("t2_stage_b", 32'(mt_stage_o), 32'd1);
    step_unit(1, 32'h8);
    check("t2_addr_b", ex_start_addr_o, 32'h110);
    check("t2_args_b", ex_args_addr_o, 32'h8);
    step_unit(2, 0);
    check("t2_gap_b", 32'({ps_start_o, mt_start_o, ex_start_o}), 32'd0);
    tick();
    check("t2_stage_c", 32'(mt_stage_o), 32'd3);
    step_unit(1, 32'h0);
    check("t2_addr_c", ex_start_addr_o, 32'h230);
    step_unit(2, 0);
    check("t2_ready", 32'(ready_o), 32'd1);
    check("t2_hitvec", 32'(hit_vec_o), 32'h2);
    end_packet();
    $display("pkt multi_stage ready=%0b hit_vec=%b", ready_o, hit_vec_o);

    // Empty table: parser only.
    cfg(0, 32'h100, 32'h200, 1'b0);
    cfg(1, 32'h110, 32'h210, 1'b0);
    cfg(3, 32'h130, 32'h230, 1'b0);
    start_i = 1'b1;
    tick();
    step_unit(0, 0);
    check("t3_ready", 32'(ready_o), 32'd1);
    check("t3_mt_start", 32'(mt_start_o), 32'd0);
    check("t3_busy", 32'(busy_o), 32'd0);
    tick();
    check("t3_mt_later", 32'(mt_start_o), 32'd0);
    end_packet();
    $display("pkt no_stage ready=%0b", ready_o);

    // Config with start in IDLE wins; config during MATCH is dropped.
    cfg_we_i = 1'b1; cfg_stage_i = 2'd0; cfg_hit_addr_i = 32'h300; cfg_miss_addr_i = 32'h400; cfg_en_i = 1'b1;
    start_i = 1'b1;
    tick();
    cfg_we_i = 1'b0;
    check("t4_deferred", 32'(ps_start_o), 32'd0);
    tick();
    check("t4_ps_start", 32'(ps_start_o), 32'd1);
    step_unit(0, 0);
    check("t4_mt_start", 32'(mt_start_o), 32'd1);
    cfg(0, 32'h500, 32'h600, 1'b1);
    cfg(2, 32'h520, 32'h620, 1'b1);
    step_unit(1, 32'h44);
    check("t4_ex_addr", ex_start_addr_o, 32'h300);
    step_unit(2, 0);
    check("t4_no_gap", 32'(ready_o), 32'd1);
    end_packet();
    $display("pkt cfg_gating ex_addr=%0h", ex_start_addr_o);

    // Executor never answers: watchdog aborts after 8 cycles in EXEC.
    start_i = 1'b1;
    tick();
    step_unit(0, 0);
    step_unit(1, 32'h0);
    n = 0;
    while (ex_start_o === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("t5_exec_cycles", 32'(n), 32'd8);
    check("t5_err", 32'(err_o), 32'd1);
    check("t5_ready", 32'(ready_o), 32'd1);
    end_packet();
    start_i = 1'b1;
    tick();
    check("t5_err_clr", 32'(err_o), 32'd0);
    step_unit(0, 0);
    step_unit(1, 32'h0);
    check("t5_miss_addr", ex_start_addr_o, 32'h400);
    step_unit(2, 0);
    check("t5_ok_ready", 32'(ready_o), 32'd1);
    check("t5_ok_err", 32'(err_o), 32'd0);
    end_packet();
    $display("pkt timeout cycles=%0d", n);

    // Reset while the executor is running.
    start_i = 1'b1;
    tick();
    step_unit(0, 0);
    step_unit(1, 32'h40);
    rst = 1'b0;
    #1;
    check("t6_ex_start", 32'(ex_start_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_memce", 32'(mem_ce_o), 32'd0);
    check("t6_hitvec", 32'(hit_vec_o), 32'd0);
    check("t6_ex_addr", ex_start_addr_o, 32'd0);
    check("t6_args", ex_args_addr_o, 32'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start_i = 1'b1;
    tick();
    step_unit(0, 0);
    check("t6_empty_ready", 32'(ready_o), 32'd1);
    check("t6_empty_mt", 32'(mt_start_o), 32'd0);
    end_packet();
    $display("pkt reset_mid_exec ready=%0b", ready_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
